// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN (defined at build time) adds the signed-overflow output.
package serial_sub_pkg;

    localparam int unsigned WidthMin = 1;
    localparam int unsigned WidthMax = 32;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock behind a start/busy/done handshake.
// Optional SERIAL_SUB_OVF_EN adds the ovf port and the captured sign flops.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_q, diff_d;
    logic [CntW-1:0]  cnt_q;
    logic             borrow_q, bout_q;
    logic             cell_d, cell_bout;
    logic             accept, shift, last;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        accept = (state_q == StIdle) && start;
        shift  = (state_q == StShift);
        last   = shift && (cnt_q == CntLast);
    end

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at diff[0].
    if (WIDTH == 1) begin : g_diff_w1
        always_comb diff_d = cell_d;
    end else begin : g_diff_wn
        always_comb diff_d = {cell_d, diff_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == CntLast) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
        diff = diff_q;
        bout = bout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else if (accept) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
        end else if (shift) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            borrow_q <= cell_bout;
            diff_q   <= diff_d;
            if (last) begin
                bout_q <= cell_bout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_sign_q, b_sign_q, ovf_q;

    // cell_d on the last shift is the final result sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_sign_q <= a[WIDTH-1];
            b_sign_q <= b[WIDTH-1];
        end else if (last) begin
            ovf_q <= (a_sign_q != b_sign_q) && (cell_d != a_sign_q);
        end
    end

    always_comb ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Build with SERIAL_SUB_OVF_EN defined to also check ovf.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start1, a1, b1, bin1, busy1, done1, diff1, bout1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full WIDTH=8 operation from IDLE; returns in the first IDLE cycle after done.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic binv, input logic [7:0] ed, input logic eb, input logic eo);
        int lat;
        a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
        tick;
        start8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~binv;
        chk({tag, "_busy_shift"}, busy8, 1);
        chk({tag, "_done_shift"}, done8, 0);
        lat = 1;
        while (!done8 && lat < 20) begin
            tick;
            lat++;
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_busy_done"}, busy8, 1);
        chk({tag, "_diff"}, diff8, ed);
        chk({tag, "_bout"}, bout8, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, ovf8, eo);
`endif
        tick;
        chk({tag, "_done_pulse"}, done8, 0);
        chk({tag, "_busy_idle"}, busy8, 0);
        chk({tag, "_diff_hold"}, diff8, ed);
        chk({tag, "_bout_hold"}, bout8, eb);
    endtask

    initial begin
        int lat, ndone, ac, ea, eb, er;
        logic seen;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_bout", bout8, 0);
        chk("rst_busy_w1", busy1, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf8, 0);
`endif
        tick;
        tick;
        rst = 1'b0;
        tick;

        op8("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        op8("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        op8("sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // start held high with operands changing every cycle; accepts at cycles 0, 10, 20.
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            a8 = 8'(c * 7 + 3);
            b8 = 8'(c * 13 + 1);
            bin8 = c[0];
            start8 = 1'b1;
            if (done8) begin
                chk("held_done_cycle", c, 10 * ndone + 9);
                ac = 10 * ndone;
                ea = (ac * 7 + 3) % 256;
                eb = (ac * 13 + 1) % 256;
                er = ea - eb - (ac % 2);
                chk("held_diff", diff8, 32'(er & 255));
                chk("held_bout", bout8, (er < 0) ? 1 : 0);
                ndone++;
            end
            tick;
        end
        start8 = 1'b0;
        chk("held_done_count", ndone, 3);
        tick;
        tick;

        // Reset in the 4th SHIFT cycle: outputs clear at once and no done follows.
        op8("pre_rst", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy8, 0);
        chk("midrst_done", done8, 0);
        chk("midrst_diff", diff8, 0);
        chk("midrst_bout", bout8, 0);
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) seen = 1'b1;
            tick;
        end
        chk("midrst_no_done", seen, 0);
        op8("after_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

        // WIDTH=1 full-subtractor truth table.
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
            er = i / 4 - (i / 2) % 2 - i % 2;
            tick;
            start1 = 1'b0;
            lat = 1;
            while (!done1 && lat < 6) begin
                tick;
                lat++;
            end
            chk("w1_latency", lat, 2);
            chk("w1_diff", diff1, 32'(er & 1));
            chk("w1_bout", bout1, (er < 0) ? 1 : 0);
            tick;
            chk("w1_idle", busy1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
